// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard/forwarding control.
// Also holds the forward-select priority rule used by E and D stages.
package pipeline_pkg;

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] MEM_WAIT = 2'b01;
  localparam logic [1:0] MDU_WAIT = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M beats W; $0 is hardwired zero so it never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wreg_m,
    input logic       rw_m,
    input logic [4:0] wreg_w,
    input logic       rw_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0 && src == wreg_m && rw_m)
      sel = FWD_M;
    else if (src != 5'd0 && src == wreg_w && rw_w)
      sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding for the E-stage ALU
// and the D-stage branch comparator.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  assign forwardAE = fwd_sel(rsE, writeregM, regwriteM,
                             writeregW, regwriteW);
  assign forwardBE = fwd_sel(rtE, writeregM, regwriteM,
                             writeregW, regwriteW);

  assign forwardAD = (rsD != 5'd0) && (rsD == writeregM)
                     && regwriteM;
  assign forwardBD = (rtD != 5'd0) && (rtD == writeregM)
                     && regwriteM;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard priority,
// status FSM, MDU busy counter and stall-cycle counter.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             pcsrcD,
  input  logic             memaccessM,
  input  logic             dmem_ready,
  input  logic             mdu_startE,
  input  logic             hiloreadD,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [3:0] mdu_cnt;
  logic [3:0] mdu_cnt_nxt;
  logic [1:0] state_nxt;
  logic       lwstall;
  logic       brstall;
  logic       memwait;
  logic       mdubusy;
  logic       dep_e;
  logic       dep_m;

  forward_unit u_fwd (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .forwardAD (forwardAD),
    .forwardBD (forwardBD),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE)
  );

  assign dep_e = (writeregE == rsD) || (writeregE == rtD);
  assign dep_m = (writeregM == rsD) || (writeregM == rtD);

  assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign brstall = branchD && ((regwriteE && dep_e) ||
                               (memtoregM && dep_m));
  assign memwait = memaccessM && !dmem_ready;
  assign mdubusy = (mdu_cnt != 4'd0) && hiloreadD;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (memwait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (mdubusy || lwstall || brstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (pcsrcD) begin
      flushD = 1'b1;
    end
  end

  // A fresh op entering E reloads even if the previous one is still running
  always_comb begin
    mdu_cnt_nxt = mdu_cnt;
    if (mdu_startE && !stallE)
      mdu_cnt_nxt = 4'(MDU_LATENCY);
    else if (mdu_cnt != 4'd0)
      mdu_cnt_nxt = mdu_cnt - 4'd1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (memwait)
          state_nxt = MEM_WAIT;
        else if (mdubusy)
          state_nxt = MDU_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_ready)
          state_nxt = RUN;
      end
      MDU_WAIT: begin
        if (memwait)
          state_nxt = MEM_WAIT;
        else if (mdu_cnt_nxt == 4'd0)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= RUN;
      mdu_cnt      <= 4'd0;
      stall_cycles <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
      if (stallF && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: directed test-plan sequences plus random traffic
// against a behavioural model of the hazard rules.
module tb_hazard_controller;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic rwE, rwM, rwW, mtrE, mtrM, brD, pcsrc;
    logic macc, rdy, start, hilo, rst;
  } stim_t;

  typedef struct {
    logic [6:0]    ctl;
    logic [5:0]    fwd;
    logic [1:0]    st;
    logic [CW-1:0] sc;
  } exp_t;

  logic CLK = 1'b0;
  logic reset;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW;
  logic memtoregE, memtoregM, branchD, pcsrcD;
  logic memaccessM, dmem_ready, mdu_startE, hiloreadD;
  logic stallF, stallD, stallE, stallM;
  logic flushD, flushE, flushW;
  logic forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE, state;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  int m_cnt = 0;
  int m_state = 0;
  int m_sc = 0;

  always #5 CLK = ~CLK;

  hazard_controller #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM),
    .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .pcsrcD(pcsrcD),
    .memaccessM(memaccessM), .dmem_ready(dmem_ready),
    .mdu_startE(mdu_startE), .hiloreadD(hiloreadD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .flushD(flushD), .flushE(flushE),
    .flushW(flushW), .forwardAD(forwardAD),
    .forwardBD(forwardBD), .forwardAE(forwardAE),
    .forwardBE(forwardBE), .state(state),
    .stall_cycles(stall_cycles)
  );

  function automatic int fsel(int src, int wm, bit rm,
                              int ww, bit rw);
    if (src != 0 && src == wm && rm) return 2;
    if (src != 0 && src == ww && rw) return 1;
    return 0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rsD = 0; s.rtD = 0; s.rsE = 0; s.rtE = 0;
    s.wE = 0; s.wM = 0; s.wW = 0;
    s.rwE = 0; s.rwM = 0; s.rwW = 0;
    s.mtrE = 0; s.mtrM = 0; s.brD = 0; s.pcsrc = 0;
    s.macc = 0; s.rdy = 1; s.start = 0; s.hilo = 0;
    s.rst = 0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rsD = 5'($urandom_range(0, 3));
    s.rtD = 5'($urandom_range(0, 3));
    s.rsE = 5'($urandom_range(0, 3));
    s.rtE = 5'($urandom_range(0, 3));
    s.wE = 5'($urandom_range(0, 3));
    s.wM = 5'($urandom_range(0, 3));
    s.wW = 5'($urandom_range(0, 3));
    s.rwE = 1'($urandom); s.rwM = 1'($urandom);
    s.rwW = 1'($urandom);
    s.mtrE = ($urandom_range(0, 3) == 0);
    s.mtrM = ($urandom_range(0, 3) == 0);
    s.brD = ($urandom_range(0, 2) == 0);
    s.pcsrc = ($urandom_range(0, 2) == 0);
    s.macc = ($urandom_range(0, 2) == 0);
    s.rdy = ($urandom_range(0, 2) != 0);
    s.start = ($urandom_range(0, 5) == 0);
    s.hilo = ($urandom_range(0, 2) == 0);
    s.rst = ($urandom_range(0, 60) == 0);
    return s;
  endfunction

  // Apply one cycle of stimulus, predict its outputs, advance the model
  task automatic drive(input stim_t s);
    exp_t e;
    bit mw, mb, lw, br, sF, sD, sE, sM, fD, fE, fW;
    int nc;
    @(negedge CLK);
    rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
    writeregE = s.wE; writeregM = s.wM; writeregW = s.wW;
    regwriteE = s.rwE; regwriteM = s.rwM; regwriteW = s.rwW;
    memtoregE = s.mtrE; memtoregM = s.mtrM;
    branchD = s.brD; pcsrcD = s.pcsrc;
    memaccessM = s.macc; dmem_ready = s.rdy;
    mdu_startE = s.start; hiloreadD = s.hilo; reset = s.rst;

    mw = s.macc && !s.rdy;
    mb = (m_cnt > 0) && s.hilo;
    lw = s.mtrE && (s.rtE == s.rsD || s.rtE == s.rtD);
    br = s.brD && ((s.rwE && (s.wE == s.rsD || s.wE == s.rtD))
       || (s.mtrM && (s.wM == s.rsD || s.wM == s.rtD)));
    sF = mw || mb || lw || br;
    sD = sF;
    sE = mw;
    sM = mw;
    fW = mw;
    fE = !mw && (mb || lw || br);
    fD = !sF && s.pcsrc;
    e.ctl = {sF, sD, sE, sM, fD, fE, fW};
    e.fwd[5] = (s.rsD != 0 && s.rsD == s.wM && s.rwM);
    e.fwd[4] = (s.rtD != 0 && s.rtD == s.wM && s.rwM);
    e.fwd[3:2] = 2'(fsel(s.rsE, s.wM, s.rwM, s.wW, s.rwW));
    e.fwd[1:0] = 2'(fsel(s.rtE, s.wM, s.rwM, s.wW, s.rwW));
    e.st = 2'(m_state);
    e.sc = CW'(m_sc);
    sb.push_back(e);

    if (s.rst) begin
      m_state = 0; m_cnt = 0; m_sc = 0;
    end else begin
      if (sF && m_sc < SAT) m_sc++;
      nc = (s.start && !mw) ? LAT : (m_cnt > 0 ? m_cnt - 1 : 0);
      if (m_state == 0)
        m_state = mw ? 1 : (mb ? 2 : 0);
      else if (m_state == 1)
        m_state = s.rdy ? 0 : 1;
      else
        m_state = mw ? 1 : (nc == 0 ? 0 : 2);
      m_cnt = nc;
    end
  endtask

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h",
               nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("ctl", int'({stallF, stallD, stallE, stallM,
                         flushD, flushE, flushW}), int'(e.ctl));
        cmp("fwd", int'({forwardAD, forwardBD, forwardAE,
                         forwardBE}), int'(e.fwd));
        cmp("state", int'(state), int'(e.st));
        cmp("stall_cycles", int'(stall_cycles), int'(e.sc));
      end
    end
  end

  initial begin : stim
    stim_t s;
    reset = 1'b1;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; branchD = 0; pcsrcD = 0;
    memaccessM = 0; dmem_ready = 1; mdu_startE = 0;
    hiloreadD = 0;
    @(posedge CLK);
    @(posedge CLK);

    s = idle(); drive(s); drive(s);

    s = idle(); s.mtrE = 1; s.rtE = 5; s.rsD = 5; drive(s);
    s = idle(); s.rsE = 5; s.wM = 5; s.rwM = 1; drive(s);

    s = idle(); s.rsE = 3; s.wM = 3; s.wW = 3;
    s.rwM = 1; s.rwW = 1; drive(s);
    s.rsE = 0; s.rtE = 3; drive(s);

    s = idle(); s.macc = 1; s.rdy = 0;
    repeat (3) drive(s);
    s.rdy = 1; drive(s);
    s = idle(); drive(s);

    s = idle(); s.start = 1; drive(s);
    s = idle(); s.hilo = 1;
    repeat (6) drive(s);

    s = idle(); s.brD = 1; s.pcsrc = 1; s.rsD = 2; s.rtD = 4;
    drive(s);
    s.rwE = 1; s.wE = 2; drive(s);
    s.rwE = 0; s.wE = 0; drive(s);

    s = idle(); s.start = 1; drive(s);
    s = idle(); s.hilo = 1; drive(s); drive(s);
    s.rst = 1; drive(s);
    s.rst = 0; drive(s); drive(s);

    s = idle(); s.macc = 1; s.rdy = 0;
    repeat (20) drive(s);
    s.rdy = 1; drive(s);

    for (int i = 0; i < 3000; i++) drive(rnd());

    s = idle(); drive(s);
    repeat (3) @(negedge CLK);
    #3;
    cmp("drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central hazard and stall sequencer for the 5-stage MIPS pipeline. It drives the enable/clear controls of every pipeline register:
- `stallF` goes to the PC register.
- `stallD` goes to the fetch/decode register's `nEN`.
- `flushD`, `flushE`, `stallE`, `stallM` and `flushW` go to the downstream stage registers.

It also selects operand forwarding. A small FSM and counters sequence multi-cycle waits: data-memory not-ready and the multiply/divide unit (MDU) busy window.

## Interface
- `MDU_LATENCY`, default 4: cycles an MDU op occupies HI/LO after leaving E (range 2–15).
- `CNT_W`, default 16: width of the stall-cycle performance counter.

Ports:
- `CLK`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `rsD`, `rtD`  in  5 each  source registers in D
- `rsE`, `rtE`  in  5 each  source registers in E
- `writeregE`, `writeregM`, `writeregW`  in  5 each  destination registers
- `regwriteE`, `regwriteM`, `regwriteW`  in  1 each  register-write enables
- `memtoregE`, `memtoregM`  in  1 each  load in stage
- `branchD`  in  1  branch in D
- `pcsrcD`  in  1  branch/jump taken, resolved in D
- `memaccessM`  in  1  load/store in M
- `dmem_ready`  in  1  data memory completes this cycle
- `mdu_startE`  in  1  mult/div in E
- `hiloreadD`  in  1  mfhi/mflo or mult/div in D
- `stallF`, `stallD`, `stallE`, `stallM`  out  1 each  hold stage register
- `flushD`, `flushE`, `flushW`  out  1 each  clear stage register
- `forwardAD`, `forwardBD`  out  1 each  D-stage comparator forward from M
- `forwardAE`, `forwardBE`  out  2 each  ALU operand select: 00 regfile, 01 from W, 10 from M
- `state`  out  2  00 RUN, 01 MEM_WAIT, 10 MDU_WAIT
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `stallF`=1

## Operation
Forwarding (combinational, register $0 never forwarded):
- `forwardAE` = 10 if `rsE`≠0, `rsE`==`writeregM` and `regwriteM`.
- Otherwise `forwardAE` = 01 if `rsE`≠0, `rsE`==`writeregW` and `regwriteW`.
- Otherwise `forwardAE` = 00.
- `forwardBE` is the same with `rtE`.
- `forwardAD` = `rsD`≠0 & `rsD`==`writeregM` & `regwriteM`. `forwardBD` is the same with `rtD`.

Hazard terms:
- `lwstall` = `memtoregE` & (`rtE`==`rsD` | `rtE`==`rtD`).
- `brstall` = `branchD` & ((`regwriteE` & `writeregE`∈{`rsD`,`rtD`}) | (`memtoregM` & `writeregM`∈{`rsD`,`rtD`})).
- `memwait` = `memaccessM` & !`dmem_ready`.
- `mdubusy` = `mdu_cnt`≠0 & `hiloreadD`.

Priority, highest first (the outputs listed are 1; all other controls are 0):
1. `memwait`: `stallF`, `stallD`, `stallE`, `stallM`, `flushW`.
2. `mdubusy`: `stallF`, `stallD`, `flushE`.
3. `lwstall` | `brstall`: `stallF`, `stallD`, `flushE`.
4. `pcsrcD` with no stall: `flushD`.

FSM (registered, status only; all stall outputs come from the current-cycle terms above):
- RUN → MEM_WAIT when `memwait`.
- MEM_WAIT → RUN on the first cycle `dmem_ready`=1.
- RUN → MDU_WAIT when `mdubusy` and not `memwait`.
- MDU_WAIT → RUN when `mdu_cnt` reaches 0.
- From MDU_WAIT, `memwait` moves the FSM to MEM_WAIT.

MDU counter `mdu_cnt` (4 bits):
- Loaded with `MDU_LATENCY` when `mdu_startE` & !`stallE`.
- Otherwise decrements by 1 per cycle while nonzero, including during `memwait`.
- If a load and a nonzero value coincide, the load wins.

`stall_cycles`: increments each cycle `stallF`=1 and saturates at all-ones.

## Timing
- All stall, flush and forward outputs are combinational from inputs plus registered `mdu_cnt`, with zero-cycle latency, so a stage register holds in the same edge.
- `state`, `mdu_cnt` and `stall_cycles` update on the rising edge of `CLK`.
- Reset (edge with `reset`=1) sets `state`=RUN, `mdu_cnt`=0, `stall_cycles`=0. All outputs are then 0, apart from forwarding derived from its inputs.
- Reset mid-operation abandons any wait immediately; the next cycle is RUN with no stall.
- A load-use stall lasts exactly 1 cycle.
- `brstall` lasts 1 cycle on an E-stage producer and 1 cycle on an M-stage load.
- An MDU read issued the cycle after `mdu_startE` stalls `MDU_LATENCY` cycles.
- `pcsrcD` coinciding with any stall produces no `flushD`; the flush occurs when the stall clears.

## Structure
- Shared package `pipeline_pkg`: state encodings RUN/MEM_WAIT/MDU_WAIT and the forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10.
- Natural sub-module: `forward_unit` (pure combinational E/D forwarding). The FSM, counters and priority logic stay in `hazard_controller`.

## Test plan
- **Load-use:** `memtoregE`=1, `rtE`=5, `rsD`=5 → one cycle with `stallF`=`stallD`=`flushE`=1; the next cycle `forwardAE`=10.
- **Forward precedence:** `rsE`=3 with `writeregM`=`writeregW`=3 and `regwriteM`=`regwriteW`=1 → `forwardAE`=10. With `rsE`=0 and all matches → 00.
- **Memory wait:** `memaccessM`=1, `dmem_ready` low for 3 cycles → `state`=MEM_WAIT and all four stalls plus `flushW` asserted for 3 cycles; `stall_cycles` increases by 3; RUN on the ready cycle.
- **MDU:** `mdu_startE` then `hiloreadD` the next cycle with `MDU_LATENCY`=4 → `stallD`=1 for 4 cycles with `state`=MDU_WAIT, then RUN.
- **Taken branch:** `branchD`=`pcsrcD`=1, no dependency → `flushD`=1 for one cycle, no stall. With `regwriteE`=1 and `writeregE`=`rsD` → 1 stall cycle, then `flushD`.
- **Reset mid-MDU_WAIT:** `mdu_cnt`=3 when `reset` is asserted → next cycle `state`=RUN, `mdu_cnt`=0, all stalls 0, `stall_cycles`=0.
